risc_int_ctrl: RTL

Vectored interrupt controller that sits between external interrupt sources and the RISC core's INT/PC-redirect path. It latches source edges into a pending register and applies a mask. Pending requests are arbitrated by fixed priority. The controller sequences a request/acknowledge/return handshake with the core: it raises a request only at an instruction boundary, supplies the handler vector, and tracks which source is in service until the core executes a return-from-interrupt.

---
 rtl/risc_int_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/risc_int_ctrl.sv
// Vectored interrupt controller: edge-latched pending sources, mask, fixed-priority
// arbitration, and a req/ack/reti handshake with the core at instruction boundaries.
module risc_int_ctrl #(
    parameter int unsigned ID_W       = 2,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0040,
    parameter int unsigned VEC_STRIDE = 4,
    localparam int unsigned NSRC      = 2**ID_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            instr_done,
    input  logic            int_ack,
    input  logic            reti,
    output logic            int_req,
    output logic [31:0]     int_vec,
    output logic [ID_W-1:0] int_id,
    output logic [NSRC-1:0] mask,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    logic [NSRC-1:0] r_src_d;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_in_service;
    logic            r_int_req;
    logic [ID_W-1:0] r_int_id;
    logic [31:0]     r_int_vec;

    state_t          w_state_nxt;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_eligible;
    logic [ID_W-1:0] w_winner;
    logic [NSRC-1:0] w_id_onehot;
    logic [NSRC-1:0] w_pend_clr;
    logic [NSRC-1:0] w_in_service_nxt;
    logic            w_int_req_nxt;
    logic [ID_W-1:0] w_int_id_nxt;
    logic [31:0]     w_int_vec_nxt;

    assign w_rise      = src_in & ~r_src_d;
    assign w_eligible  = r_pending & ~r_mask;
    assign w_id_onehot = NSRC'(1) << r_int_id;

    // Lowest set index wins: scanning downward lets the lowest index overwrite last.
    always_comb begin
        w_winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_int_req_nxt    = r_int_req;
        w_int_id_nxt     = r_int_id;
        w_int_vec_nxt    = r_int_vec;
        w_in_service_nxt = r_in_service;
        w_pend_clr       = '0;
        unique case (r_state)
            IDLE: begin
                if ((w_eligible != '0) && instr_done) begin
                    w_state_nxt   = REQ;
                    w_int_req_nxt = 1'b1;
                    w_int_id_nxt  = w_winner;
                    w_int_vec_nxt = VEC_BASE + 32'(w_winner) * 32'(VEC_STRIDE);
                end
            end
            REQ: begin
                if (int_ack) begin
                    w_state_nxt      = SERVICE;
                    w_int_req_nxt    = 1'b0;
                    w_pend_clr       = w_id_onehot;
                    w_in_service_nxt = w_id_onehot;
                end
            end
            SERVICE: begin
                if (reti) begin
                    w_state_nxt      = IDLE;
                    w_in_service_nxt = '0;
                end
            end
            default: begin
                w_state_nxt      = IDLE;
                w_int_req_nxt    = 1'b0;
                w_in_service_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_src_d      <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_in_service <= '0;
            r_int_req    <= 1'b0;
            r_int_id     <= '0;
            r_int_vec    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_src_d      <= src_in;
            // A fresh edge on the acknowledged source outranks the ack's clear.
            r_pending    <= (r_pending & ~w_pend_clr) | w_rise;
            r_in_service <= w_in_service_nxt;
            r_int_req    <= w_int_req_nxt;
            r_int_id     <= w_int_id_nxt;
            r_int_vec    <= w_int_vec_nxt;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    assign int_req    = r_int_req;
    assign int_vec    = r_int_vec;
    assign int_id     = r_int_id;
    assign mask       = r_mask;
    assign pending    = r_pending;
    assign in_service = r_in_service;

endmodule
